// File: rtl/ecc_mon_pkg.sv
// Shared constants for the ECC error monitor: flag indices, readout select
// codes and the bit layout of the status word.
package ecc_mon_pkg;

    // Flag positions within flag_in / the per-flag vectors
    localparam int NUM_FLAGS   = 3;
    localparam int FLAG_CORR   = 0;
    localparam int FLAG_UNCORR = 1;
    localparam int FLAG_CHK    = 2;

    // Readout select codes for rd_sel
    typedef enum logic [1:0] {
        SEL_CORR   = 2'd0,
        SEL_UNCORR = 2'd1,
        SEL_CHK    = 2'd2,
        SEL_STATUS = 2'd3
    } rd_sel_e;

    // Status word layout; the irq bit needs a readout at least 9 bits wide
    localparam int STAT_STICKY_LSB = 0;
    localparam int STAT_OVF_LSB    = 4;
    localparam int STAT_IRQ_BIT    = 8;
    localparam int STAT_MIN_W      = STAT_IRQ_BIT + 1;

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into an output held high for exactly
// STRETCH_CYCLES cycles after the most recent trigger. A retrigger while
// active reloads the timer, so the output never drops between events.
module pulse_stretcher #(
    parameter int STRETCH_CYCLES = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out
);

    localparam int            TW     = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STRETCH_CYCLES - 1);

    logic [TW-1:0] timer;

    // Load on trigger, count down while active, drop the output when spent
    always_ff @(posedge clk) begin
        // NOTE: registered state always uses <= so every flop samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            timer <= '0;
            out   <= 1'b0;
        end else if (trig) begin
            timer <= RELOAD;
            out   <= 1'b1;
        end else if (timer != '0) begin
            timer <= timer - TW'(1);
        end else begin
            out <= 1'b0;
        end
    end

endmodule

// File: rtl/ecc_error_monitor.sv
// ECC flag monitor: synchronises the three ECC flags into clk, edge-detects
// them, keeps saturating per-flag event counters with sticky/overflow status,
// drives stretched LED pulses and a level interrupt on uncorrectable errors.
// The status word occupies bits [8:0], so CNT_W must be at least 9.
module ecc_error_monitor
    import ecc_mon_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int STRETCH_CYCLES = 12500000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_FLAGS-1:0] flag_in,
    input  logic                 mon_clear,
    input  logic [1:0]           rd_sel,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 led_corr,
    output logic                 led_uncorr,
    output logic                 irq
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam int                MASK_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(SYNC_STAGES + 1);

    logic [NUM_FLAGS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_FLAGS-1:0] s_prev;
    logic [MASK_W-1:0]    mask_cnt;
    logic [NUM_FLAGS-1:0] evt;

    logic [CNT_W-1:0]     cnt [NUM_FLAGS];
    logic [NUM_FLAGS-1:0] sticky;
    logic [NUM_FLAGS-1:0] ovf;
    logic [CNT_W-1:0]     status;

    // Synchroniser chain, delayed copy for edge detect, post-reset edge mask
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this small flop array is reset element by element; the
            // edge mask below assumes every stage starts from a known 0.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            s_prev   <= '0;
            mask_cnt <= MASK_INIT;
        end else begin
            sync_q[0] <= flag_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            s_prev <= sync_q[SYNC_STAGES-1];
            if (mask_cnt != '0) begin
                mask_cnt <= mask_cnt - MASK_W'(1);
            end
        end
    end

    // A flag held high through reset looks like a 0->1 edge as the zeroed
    // chain refills; suppress edges until the chain holds real samples.
    assign evt = (mask_cnt == '0) ? (sync_q[SYNC_STAGES-1] & ~s_prev) : '0;

    // Saturating counters, sticky/overflow bits and irq; a clear that
    // coincides with an event keeps that event
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                cnt[i] <= '0;
            end
            sticky <= '0;
            ovf    <= '0;
            irq    <= 1'b0;
        end else if (mon_clear) begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                cnt[i] <= evt[i] ? CNT_ONE : '0;
            end
            sticky <= evt;
            ovf    <= '0;
            irq    <= evt[FLAG_UNCORR];
        end else begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (evt[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
            sticky <= sticky | evt;
            if (evt[FLAG_UNCORR]) begin
                irq <= 1'b1;
            end
        end
    end

    // Assemble the status word and select the readout
    always_comb begin
        // NOTE: defaults before any branch so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        status                                  = '0;
        status[STAT_STICKY_LSB +: NUM_FLAGS]    = sticky;
        status[STAT_OVF_LSB    +: NUM_FLAGS]    = ovf;
        status[STAT_IRQ_BIT]                    = irq;
        rd_data                                 = '0;
        case (rd_sel_e'(rd_sel))
            SEL_CORR:   rd_data = cnt[FLAG_CORR];
            SEL_UNCORR: rd_data = cnt[FLAG_UNCORR];
            SEL_CHK:    rd_data = cnt[FLAG_CHK];
            SEL_STATUS: rd_data = status;
            default:    rd_data = '0;
        endcase
    end

    pulse_stretcher #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_led_corr (
        .clk   (clk),
        .reset (reset),
        .trig  (evt[FLAG_CORR]),
        .out   (led_corr)
    );

    pulse_stretcher #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_led_uncorr (
        .clk   (clk),
        .reset (reset),
        .trig  (evt[FLAG_UNCORR]),
        .out   (led_uncorr)
    );

endmodule

// File: tb/tb_ecc_error_monitor.sv
// Directed bench for ecc_error_monitor. Counter width is reduced to 10 bits
// so saturation is reachable in a few thousand cycles; the LED stretch is 8.
module tb_ecc_error_monitor;

    localparam int CNT_W   = 10;
    localparam int STRETCH = 8;
    localparam int SYNC    = 2;
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       flag_in;
    logic             mon_clear;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             led_corr;
    logic             led_uncorr;
    logic             irq;

    int errors = 0;
    int checks = 0;

    ecc_error_monitor #(
        .CNT_W         (CNT_W),
        .STRETCH_CYCLES(STRETCH),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flag_in   (flag_in),
        .mon_clear (mon_clear),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .led_corr  (led_corr),
        .led_uncorr(led_uncorr),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge
    task automatic read_sel(input logic [1:0] sel, output logic [CNT_W-1:0] val);
        rd_sel = sel;
        #1;
        val = rd_data;
    endtask

    task automatic pulse_clear();
        @(negedge clk) mon_clear = 1'b1;
        @(negedge clk) mon_clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] v;
        reset     = 1'b1;
        flag_in   = 3'b111;
        mon_clear = 1'b0;
        rd_sel    = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_rd_sel%0d: got %h expected 0", s, v);
            end
        end
        checks++;
        if ({led_corr, led_uncorr, irq} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: led_corr/led_uncorr/irq got %b expected 000",
                     {led_corr, led_uncorr, irq});
        end
        flag_in = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_event();
        logic [CNT_W-1:0] v;
        int hi;
        @(negedge clk) flag_in = 3'b001;
        @(negedge clk);
        @(negedge clk);
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd0) begin
            errors++;
            $display("FAIL single_latency_early: corr got %0d expected 0", v);
        end
        @(negedge clk);
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd1) begin
            errors++;
            $display("FAIL single_count: corr got %0d expected 1", v);
        end
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            if (led_corr) hi++;
            if (c == 2) flag_in = 3'b000;
            @(negedge clk);
        end
        checks++;
        if (hi != STRETCH) begin
            errors++;
            $display("FAIL single_led_width: got %0d cycles expected %0d", hi, STRETCH);
        end
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd1) begin
            errors++;
            $display("FAIL single_level_once: corr got %0d expected 1", v);
        end
        read_sel(2'd3, v);
        checks++;
        if (v !== 10'h001) begin
            errors++;
            $display("FAIL single_status: got %h expected 001", v);
        end
    endtask

    task automatic test_simultaneous();
        logic [CNT_W-1:0] v;
        int hi;
        pulse_clear();
        @(negedge clk) flag_in = 3'b111;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            read_sel(2'(s), v);
            checks++;
            if (v !== 10'd1) begin
                errors++;
                $display("FAIL simul_count%0d: got %0d expected 1", s, v);
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL simul_irq: got %b expected 1", irq);
        end
        read_sel(2'd3, v);
        checks++;
        if (v !== 10'h107) begin
            errors++;
            $display("FAIL simul_status: got %h expected 107", v);
        end
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            if (led_uncorr) hi++;
            if (c == 1) flag_in = 3'b000;
            @(negedge clk);
        end
        checks++;
        if (hi != STRETCH) begin
            errors++;
            $display("FAIL simul_led_uncorr_width: got %0d expected %0d", hi, STRETCH);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] v;
        pulse_clear();
        for (int n = 0; n < 1023; n++) begin
            @(negedge clk) flag_in = 3'b100;
            @(negedge clk) flag_in = 3'b000;
        end
        repeat (4) @(negedge clk);
        read_sel(2'd2, v);
        checks++;
        if (v !== CNT_FULL) begin
            errors++;
            $display("FAIL sat_reach_max: chk got %h expected %h", v, CNT_FULL);
        end
        read_sel(2'd3, v);
        checks++;
        if (v[6] !== 1'b0) begin
            errors++;
            $display("FAIL sat_ovf_early: ovf got %b expected 0", v[6]);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk) flag_in = 3'b100;
            @(negedge clk) flag_in = 3'b000;
        end
        repeat (4) @(negedge clk);
        read_sel(2'd2, v);
        checks++;
        if (v !== CNT_FULL) begin
            errors++;
            $display("FAIL sat_no_wrap: chk got %h expected %h", v, CNT_FULL);
        end
        read_sel(2'd3, v);
        checks++;
        if (v !== 10'h044) begin
            errors++;
            $display("FAIL sat_status: got %h expected 044", v);
        end
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd0) begin
            errors++;
            $display("FAIL sat_corr_untouched: got %0d expected 0", v);
        end
    endtask

    task automatic test_clear_coincident();
        logic [CNT_W-1:0] v;
        pulse_clear();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk) flag_in = 3'b010;
            @(negedge clk) flag_in = 3'b000;
        end
        repeat (4) @(negedge clk);
        read_sel(2'd1, v);
        checks++;
        if (v !== 10'd5) begin
            errors++;
            $display("FAIL clr_prior_uncorr: got %0d expected 5", v);
        end
        // evt[1] is live between the 2nd and 3rd edges after the flag rises
        @(negedge clk) flag_in = 3'b010;
        @(negedge clk);
        @(negedge clk) mon_clear = 1'b1;
        @(negedge clk) mon_clear = 1'b0;
        read_sel(2'd1, v);
        checks++;
        if (v !== 10'd1) begin
            errors++;
            $display("FAIL clr_coincident_uncorr: got %0d expected 1", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_coincident_irq: got %b expected 1", irq);
        end
        read_sel(2'd3, v);
        checks++;
        if (v !== 10'h102) begin
            errors++;
            $display("FAIL clr_coincident_status: got %h expected 102", v);
        end
        flag_in = 3'b000;
        repeat (3) @(negedge clk);
        pulse_clear();
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL clr_plain_sel%0d: got %h expected 0", s, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_plain_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_retrigger();
        logic [CNT_W-1:0] v;
        int hi;
        int falls;
        logic prev;
        repeat (12) @(negedge clk);
        pulse_clear();
        hi    = 0;
        falls = 0;
        prev  = led_corr;
        flag_in = 3'b001;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (led_corr) hi++;
            if (prev && !led_corr) falls++;
            prev = led_corr;
            if (c == 2) flag_in = 3'b000;
            if (c == 4) flag_in = 3'b001;
            if (c == 6) flag_in = 3'b000;
        end
        checks++;
        if (hi != 12) begin
            errors++;
            $display("FAIL retrig_led_width: got %0d expected 12", hi);
        end
        checks++;
        if (falls != 1) begin
            errors++;
            $display("FAIL retrig_led_gap: falling edges got %0d expected 1", falls);
        end
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd2) begin
            errors++;
            $display("FAIL retrig_count: got %0d expected 2", v);
        end
    endtask

    task automatic test_reset_mid_stretch();
        logic [CNT_W-1:0] v;
        @(negedge clk) flag_in = 3'b011;
        repeat (4) @(negedge clk);
        checks++;
        if (led_corr !== 1'b1) begin
            errors++;
            $display("FAIL midrst_led_before: got %b expected 1", led_corr);
        end
        flag_in = 3'b000;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({led_corr, led_uncorr, irq} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_outputs: got %b expected 000",
                     {led_corr, led_uncorr, irq});
        end
        read_sel(2'd0, v);
        checks++;
        if (v !== 10'd0) begin
            errors++;
            $display("FAIL midrst_count: corr got %0d expected 0", v);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_simultaneous();
        test_saturation();
        test_clear_coincident();
        test_retrigger();
        test_reset_mid_stretch();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecc_error_monitor.md
Name: ecc_error_monitor

Overview:
Downstream consumer of the ECC datapath's 3-bit flag output (flag_out[2:0]). Synchronises the flags into the oscillator clock domain, edge-detects each flag, and keeps 16-bit saturating event counters and sticky status. It drives LED pulse-stretchers and an interrupt line on uncorrectable errors. The counters and status are readable through a 2-bit select so fault-injection campaigns (LFSR-driven) can be scored.

Parameters:
CNT_W, 16, width of each event counter and of rd_data
STRETCH_CYCLES, 12500000, LED on-time per event in clk cycles (0.25 s at 50 MHz); must be >= 1
SYNC_STAGES, 2, synchroniser depth for flag_in; must be >= 2

Ports:
clk  input  1  free-running oscillator clock
reset  input  1  synchronous, active-high reset
flag_in  input  3  ECC flags: [0] single-bit corrected, [1] uncorrectable detected, [2] parity/check-bit-only error
mon_clear  input  1  single-cycle synchronous clear of counters, sticky bits, overflow bits and irq
rd_sel  input  2  readout select: 0 corr count, 1 uncorr count, 2 check-bit count, 3 status
rd_data  output  CNT_W  combinational mux of registered counters/status per rd_sel
led_corr  output  1  stretched pulse on flag[0] events
led_uncorr  output  1  stretched pulse on flag[1] events
irq  output  1  level, set on first uncorrectable event, held until mon_clear/reset

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all sync stages, counters, sticky/overflow bits, stretch timers, irq = 0; led_corr = led_uncorr = irq = 0; rd_data = 0 for every rd_sel.
- Sync: each flag_in bit passes through SYNC_STAGES flops, then a one-flop delayed copy feeds a rising-edge detect (evt[i] = s_last & ~s_prev).
- Latency: flag_in high before edge N → evt[i] high in cycle after edge N+SYNC_STAGES-1 → counter/LED/irq updated at edge N+SYNC_STAGES. With defaults, visible 2 cycles after first sampling edge.
- One event per rising edge. A level held high counts once. Glitches shorter than one clk may be missed; no requirement to catch them.
- Counters: cnt[i] += 1 on evt[i]. At all-ones, holds and sets ovf[i]; no wrap.
- Simultaneous events on several flags in the same cycle: each counter increments independently.
- mon_clear: counters, sticky, ovf and irq go to 0 at the next edge. If evt[i] coincides with mon_clear, cnt[i] loads 1 and sticky[i] = 1, so the event is not lost. An evt[1] coincident with clear leaves irq = 1.
- mon_clear does not clear sync stages or LED timers.
- Status word (rd_sel=3): [2:0] sticky[i] (set on evt[i]); [6:4] ovf[i]; [8] irq; other bits 0.
- LED stretch: on evt, timer loads STRETCH_CYCLES-1 and LED = 1 from the next edge. LED stays high for exactly STRETCH_CYCLES cycles after the last event. A retrigger while active reloads the timer (extends); no gap.
- irq: set on evt[1]; cleared only by mon_clear/reset.
- Reset mid-stretch or mid-count: everything returns to reset values at that edge. A flag still high after reset deasserts must not produce an event; sync flops reset to 0 would create a false edge, so edge detect is masked for SYNC_STAGES+1 cycles after reset.

Decomposition:
- Shared package ecc_mon_pkg: flag index constants (FLAG_CORR=0, FLAG_UNCORR=1, FLAG_CHK=2), rd_sel codes (SEL_CORR, SEL_UNCORR, SEL_CHK, SEL_STATUS), status bit positions.
- One sub-module, pulse_stretcher (param STRETCH_CYCLES; ports clk, reset, trig, out), instantiated twice.
- Synchroniser/edge logic stays inline.

Test Plan:
- Reset and masking: reset with flag_in=3'b111, release → no counts after 10 cycles; all rd_sel read 0; LEDs 0; irq 0.
- Single event: pulse flag_in[0] high for 5 cycles → cnt corr = 1 two cycles after first sample; led_corr high exactly STRETCH_CYCLES (override 8) cycles; status = 0x0001.
- Simultaneous and irq: flag_in 3'b000→3'b111 → corr = uncorr = chk = 1; irq = 1; status = 0x0107; led_uncorr high 8 cycles.
- Saturation: 65537 rising edges on flag_in[2] → chk count = 0xFFFF; status bit 6 = 1; no wrap.
- Clear coincidence: assert mon_clear in the same cycle evt[1] fires, with prior uncorr = 5 → uncorr = 1, irq = 1, sticky[1] = 1. Plain clear → all 0, irq 0.
- Retrigger: second flag[0] edge 4 cycles into an 8-cycle stretch → led_corr continuous for 12 cycles total; count = 2.
